// File: rtl/ifu_fetch.sv
// ifu_fetch: fetch PC owner, single-outstanding imem requester, PC/inst FIFO.
// Ports: i_clk/i_rst, imem req/rsp handshake, redirect, decode-side FIFO head.
// Optional: define IFU_FETCH_PERF_EN for fetch/drop/stall counters.
module ifu_fetch #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned INST_W      = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h80000000,
  parameter int unsigned PC_STEP     = 4,
  parameter int unsigned FETCH_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_imem_req_valid,
  output logic [WIDTH-1:0]  o_imem_req_addr,
  input  logic              i_imem_req_ready,
  input  logic              i_imem_rsp_valid,
  input  logic [INST_W-1:0] i_imem_rsp_data,
  input  logic              i_redirect,
  input  logic [WIDTH-1:0]  i_redirect_pc,
  output logic              o_inst_valid,
  output logic [INST_W-1:0] o_inst,
  output logic [WIDTH-1:0]  o_inst_pc,
`ifdef IFU_FETCH_PERF_EN
  output logic [31:0]       o_perf_fetch_cnt,
  output logic [31:0]       o_perf_drop_cnt,
  output logic [31:0]       o_perf_stall_cnt,
`endif
  input  logic              i_inst_ready
);

  localparam int unsigned AW = $clog2(FETCH_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FETCH_DEPTH);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [WIDTH-1:0]  pc, pc_n;
  logic [WIDTH-1:0]  inflight_pc;
  logic [CW-1:0]     count;
  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic [INST_W-1:0] fifo_data [FETCH_DEPTH];
  logic [WIDTH-1:0]  fifo_pc   [FETCH_DEPTH];

  logic req_fire;
  logic push;
  logic pop;
  logic drop;

  assign o_imem_req_valid = (state == S_REQ) && (count < FULL)
                         && !i_redirect && !i_rst;
  assign o_imem_req_addr  = pc;
  assign req_fire = o_imem_req_valid && i_imem_req_ready;

  // A response landing together with a redirect belongs to the old path.
  assign push = (state == S_WAIT) && i_imem_rsp_valid && !i_redirect;
  assign drop = i_imem_rsp_valid
             && ((state == S_DROP) || ((state == S_WAIT) && i_redirect));

  assign o_inst_valid = (count != '0) && !i_rst;
  assign o_inst       = fifo_data[rd_ptr];
  assign o_inst_pc    = fifo_pc[rd_ptr];
  assign pop = o_inst_valid && i_inst_ready && !i_redirect;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    unique case (state)
      S_REQ: begin
        if (req_fire) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (i_imem_rsp_valid) state_n = S_REQ;
        else if (i_redirect)  state_n = S_DROP;
      end
      S_DROP: begin
        if (i_imem_rsp_valid) state_n = S_REQ;
      end
      default: state_n = S_REQ;
    endcase
    if (i_redirect)    pc_n = i_redirect_pc;
    else if (req_fire) pc_n = pc + WIDTH'(PC_STEP);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      inflight_pc <= RESET_PC;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      if (req_fire) inflight_pc <= pc;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_redirect) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push && !i_rst) begin
      fifo_data[wr_ptr] <= i_imem_rsp_data;
      fifo_pc[wr_ptr]   <= inflight_pc;
    end
  end

`ifdef IFU_FETCH_PERF_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_perf_fetch_cnt <= '0;
      o_perf_drop_cnt  <= '0;
      o_perf_stall_cnt <= '0;
    end else begin
      if (push) o_perf_fetch_cnt <= o_perf_fetch_cnt + 1'b1;
      if (drop) o_perf_drop_cnt  <= o_perf_drop_cnt + 1'b1;
      if (o_imem_req_valid && !i_imem_req_ready)
        o_perf_stall_cnt <= o_perf_stall_cnt + 1'b1;
    end
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed self-checking bench for ifu_fetch.
// One task per scenario, inline comparisons, one summary line.
module tb_ifu_fetch;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        o_imem_req_valid;
  logic [31:0] o_imem_req_addr;
  logic        i_imem_req_ready;
  logic        i_imem_rsp_valid;
  logic [31:0] i_imem_rsp_data;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        i_inst_ready;
`ifdef IFU_FETCH_PERF_EN
  logic [31:0] o_perf_fetch_cnt;
  logic [31:0] o_perf_drop_cnt;
  logic [31:0] o_perf_stall_cnt;
`endif

  int errs = 0;
  int checks = 0;
  bit auto_mem = 1'b0;
  logic [31:0] fire_q[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_dat[$];

  always #5 i_clk = ~i_clk;

  ifu_fetch dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .o_imem_req_valid (o_imem_req_valid),
    .o_imem_req_addr  (o_imem_req_addr),
    .i_imem_req_ready (i_imem_req_ready),
    .i_imem_rsp_valid (i_imem_rsp_valid),
    .i_imem_rsp_data  (i_imem_rsp_data),
    .i_redirect       (i_redirect),
    .i_redirect_pc    (i_redirect_pc),
    .o_inst_valid     (o_inst_valid),
    .o_inst           (o_inst),
    .o_inst_pc        (o_inst_pc),
`ifdef IFU_FETCH_PERF_EN
    .o_perf_fetch_cnt (o_perf_fetch_cnt),
    .o_perf_drop_cnt  (o_perf_drop_cnt),
    .o_perf_stall_cnt (o_perf_stall_cnt),
`endif
    .i_inst_ready     (i_inst_ready)
  );

  // Sample pre-edge, advance one clock, then the zero-wait
  // memory answers one cycle after each accepted request.
  task automatic cycle();
    logic        fire;
    logic [31:0] fa;
    #1;
    fire = o_imem_req_valid && i_imem_req_ready;
    fa   = o_imem_req_addr;
    if (fire) fire_q.push_back(fa);
    if (o_inst_valid && i_inst_ready && !i_redirect) begin
      pop_pc.push_back(o_inst_pc);
      pop_dat.push_back(o_inst);
    end
    @(posedge i_clk);
    #1;
    if (auto_mem) begin
      i_imem_rsp_valid = fire;
      i_imem_rsp_data  = fire ? ~fa : 32'h0;
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    auto_mem = 1'b0;
    i_imem_req_ready = 1'b0;
    i_imem_rsp_valid = 1'b0;
    i_imem_rsp_data = 32'h0;
    i_redirect = 1'b0;
    i_redirect_pc = 32'h0;
    i_inst_ready = 1'b0;
    cycle();
    cycle();
    i_rst = 1'b0;
    fire_q.delete();
    pop_pc.delete();
    pop_dat.delete();
    #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_imem_req_ready = 1'b1;
    i_imem_rsp_valid = 1'b0;
    i_imem_rsp_data = 32'h0;
    i_redirect = 1'b0;
    i_redirect_pc = 32'h0;
    i_inst_ready = 1'b0;
    #2;
    checks++;
    if (o_imem_req_valid !== 1'b0) begin
      errs++;
      $display("FAIL rst_req_valid got %b exp 0", o_imem_req_valid);
    end
    checks++;
    if (o_inst_valid !== 1'b0) begin
      errs++;
      $display("FAIL rst_inst_valid got %b exp 0", o_inst_valid);
    end
    cycle();
    cycle();
    i_rst = 1'b0;
    #1;
    checks++;
    if (o_imem_req_addr !== 32'h80000000) begin
      errs++;
      $display("FAIL rst_addr got %h exp 80000000", o_imem_req_addr);
    end
    checks++;
    if (o_imem_req_valid !== 1'b1) begin
      errs++;
      $display("FAIL rst_valid_after got %b exp 1", o_imem_req_valid);
    end
  endtask

  task automatic test_stream();
    do_reset();
    auto_mem = 1'b1;
    i_imem_req_ready = 1'b1;
    i_inst_ready = 1'b1;
    for (int i = 0; i < 7; i++) cycle();
    checks++;
    if (fire_q.size() < 1 || fire_q[0] !== 32'h80000000) begin
      errs++;
      $display("FAIL stream_first_addr got %h exp 80000000",
               fire_q.size() > 0 ? fire_q[0] : 32'hx);
    end
    checks++;
    if (pop_pc.size() !== 3) begin
      errs++;
      $display("FAIL stream_rate got %0d pops exp 3", pop_pc.size());
    end
    for (int i = 0; i < 3; i++) begin
      logic [31:0] ep;
      ep = 32'h80000000 + 32'(4 * i);
      if (i < pop_pc.size()) begin
        checks++;
        if (pop_pc[i] !== ep) begin
          errs++;
          $display("FAIL stream_pc%0d got %h exp %h", i, pop_pc[i], ep);
        end
        checks++;
        if (pop_dat[i] !== ~ep) begin
          errs++;
          $display("FAIL stream_data%0d got %h exp %h", i, pop_dat[i], ~ep);
        end
      end
    end
  endtask

  task automatic test_fill();
    do_reset();
    auto_mem = 1'b1;
    i_imem_req_ready = 1'b1;
    i_inst_ready = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    checks++;
    if (o_imem_req_valid !== 1'b0) begin
      errs++;
      $display("FAIL fill_full_valid got %b exp 0", o_imem_req_valid);
    end
    checks++;
    if (fire_q.size() !== 4) begin
      errs++;
      $display("FAIL fill_pushes got %0d exp 4", fire_q.size());
    end
    checks++;
    if (o_inst_pc !== 32'h80000000) begin
      errs++;
      $display("FAIL fill_head got %h exp 80000000", o_inst_pc);
    end
    i_inst_ready = 1'b1;
    cycle();
    i_inst_ready = 1'b0;
    #1;
    checks++;
    if (pop_pc.size() !== 1) begin
      errs++;
      $display("FAIL fill_one_pop got %0d exp 1", pop_pc.size());
    end
    checks++;
    if (o_imem_req_valid !== 1'b1 || o_imem_req_addr !== 32'h80000010) begin
      errs++;
      $display("FAIL fill_next_req got %b/%h exp 1/80000010",
               o_imem_req_valid, o_imem_req_addr);
    end
    checks++;
    if (o_inst_pc !== 32'h80000004) begin
      errs++;
      $display("FAIL fill_new_head got %h exp 80000004", o_inst_pc);
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    i_imem_req_ready = 1'b1;
    cycle();
    i_redirect = 1'b1;
    i_redirect_pc = 32'h80001000;
    cycle();
    i_redirect = 1'b0;
    cycle();
    cycle();
    #1;
    checks++;
    if (o_imem_req_valid !== 1'b0) begin
      errs++;
      $display("FAIL rdw_drop_valid got %b exp 0", o_imem_req_valid);
    end
    i_imem_rsp_valid = 1'b1;
    i_imem_rsp_data = 32'hDEADBEEF;
    cycle();
    i_imem_rsp_valid = 1'b0;
    #1;
    checks++;
    if (o_inst_valid !== 1'b0) begin
      errs++;
      $display("FAIL rdw_empty got %b exp 0", o_inst_valid);
    end
    checks++;
    if (o_imem_req_valid !== 1'b1 || o_imem_req_addr !== 32'h80001000) begin
      errs++;
      $display("FAIL rdw_req got %b/%h exp 1/80001000",
               o_imem_req_valid, o_imem_req_addr);
    end
    auto_mem = 1'b1;
    cycle();
    cycle();
    #1;
    checks++;
    if (o_inst_valid !== 1'b1 || o_inst_pc !== 32'h80001000) begin
      errs++;
      $display("FAIL rdw_tag got %b/%h exp 1/80001000", o_inst_valid, o_inst_pc);
    end
    checks++;
    if (o_inst !== ~32'h80001000) begin
      errs++;
      $display("FAIL rdw_data got %h exp %h", o_inst, ~32'h80001000);
    end
  endtask

  task automatic test_redirect_same();
    do_reset();
    auto_mem = 1'b1;
    i_imem_req_ready = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    checks++;
    if (o_inst_valid !== 1'b1 || i_imem_rsp_valid !== 1'b1) begin
      errs++;
      $display("FAIL rds_setup got %b/%b exp 1/1", o_inst_valid, i_imem_rsp_valid);
    end
    i_redirect = 1'b1;
    i_redirect_pc = 32'h80002000;
    cycle();
    i_redirect = 1'b0;
    #1;
    checks++;
    if (o_inst_valid !== 1'b0) begin
      errs++;
      $display("FAIL rds_flush got %b exp 0", o_inst_valid);
    end
    checks++;
    if (o_imem_req_valid !== 1'b1 || o_imem_req_addr !== 32'h80002000) begin
      errs++;
      $display("FAIL rds_req got %b/%h exp 1/80002000",
               o_imem_req_valid, o_imem_req_addr);
    end
    cycle();
    cycle();
    #1;
    checks++;
    if (o_inst_pc !== 32'h80002000 || o_inst !== ~32'h80002000) begin
      errs++;
      $display("FAIL rds_head got %h/%h exp 80002000/%h",
               o_inst_pc, o_inst, ~32'h80002000);
    end
  endtask

  task automatic test_stall_wrap();
    do_reset();
    auto_mem = 1'b1;
    i_inst_ready = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    #1;
    checks++;
    if (o_imem_req_addr !== 32'h80000000 || fire_q.size() !== 0) begin
      errs++;
      $display("FAIL stall_addr got %h/%0d exp 80000000/0",
               o_imem_req_addr, fire_q.size());
    end
`ifdef IFU_FETCH_PERF_EN
    checks++;
    if (o_perf_stall_cnt !== 32'd5) begin
      errs++;
      $display("FAIL stall_cnt got %0d exp 5", o_perf_stall_cnt);
    end
`endif
    i_redirect = 1'b1;
    i_redirect_pc = 32'hFFFFFFFC;
    i_imem_req_ready = 1'b1;
    cycle();
    i_redirect = 1'b0;
    #1;
    checks++;
    if (o_imem_req_addr !== 32'hFFFFFFFC) begin
      errs++;
      $display("FAIL wrap_target got %h exp fffffffc", o_imem_req_addr);
    end
    cycle();
    cycle();
    #1;
    checks++;
    if (o_imem_req_addr !== 32'h00000000) begin
      errs++;
      $display("FAIL wrap_next got %h exp 00000000", o_imem_req_addr);
    end
    checks++;
    if (o_inst_valid !== 1'b1 || o_inst_pc !== 32'hFFFFFFFC) begin
      errs++;
      $display("FAIL wrap_tag got %b/%h exp 1/fffffffc", o_inst_valid, o_inst_pc);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_imem_req_ready = 1'b1;
    cycle();
    i_rst = 1'b1;
    cycle();
    i_rst = 1'b0;
    i_imem_req_ready = 1'b0;
    i_imem_rsp_valid = 1'b1;
    i_imem_rsp_data = 32'h12345678;
    cycle();
    i_imem_rsp_valid = 1'b0;
    #1;
    checks++;
    if (o_inst_valid !== 1'b0) begin
      errs++;
      $display("FAIL rmid_empty got %b exp 0", o_inst_valid);
    end
    checks++;
    if (o_imem_req_valid !== 1'b1 || o_imem_req_addr !== 32'h80000000) begin
      errs++;
      $display("FAIL rmid_req got %b/%h exp 1/80000000",
               o_imem_req_valid, o_imem_req_addr);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill();
    test_redirect_wait();
    test_redirect_same();
    test_stall_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
